// File: rtl/elevator_pkg.sv
// Shared state encoding, direction constants and pending-mask scan helpers
// for the elevator floor controller.
package elevator_pkg;

  localparam int MAX_FLOORS  = 16;
  localparam int MAX_FLOOR_W = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR      = 2'd3
  } state_t;

  localparam logic [1:0] ST_IDLE      = IDLE;
  localparam logic [1:0] ST_MOVE_UP   = MOVE_UP;
  localparam logic [1:0] ST_MOVE_DOWN = MOVE_DOWN;
  localparam logic [1:0] ST_DOOR      = DOOR;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  function automatic logic any_above(input logic [MAX_FLOORS-1:0] mask,
                                     input logic [MAX_FLOOR_W-1:0] floor);
    logic found;
    found = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      found = found | (mask[i] & (i > int'(floor)));
    end
    return found;
  endfunction

  function automatic logic any_below(input logic [MAX_FLOORS-1:0] mask,
                                     input logic [MAX_FLOOR_W-1:0] floor);
    logic found;
    found = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      found = found | (mask[i] & (i < int'(floor)));
    end
    return found;
  endfunction

  // Scan from the far end so the last hit is the closest floor.
  function automatic logic [MAX_FLOOR_W-1:0] nearest_above(input logic [MAX_FLOORS-1:0] mask,
                                                           input logic [MAX_FLOOR_W-1:0] floor);
    logic [MAX_FLOOR_W-1:0] near;
    near = floor;
    for (int i = MAX_FLOORS - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(floor))) near = MAX_FLOOR_W'(i);
      else near = near;
    end
    return near;
  endfunction

  function automatic logic [MAX_FLOOR_W-1:0] nearest_below(input logic [MAX_FLOORS-1:0] mask,
                                                           input logic [MAX_FLOOR_W-1:0] floor);
    logic [MAX_FLOOR_W-1:0] near;
    near = floor;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if (mask[i] && (i < int'(floor))) near = MAX_FLOOR_W'(i);
      else near = near;
    end
    return near;
  endfunction

endpackage

// File: rtl/elevator_floor_ctrl_chk.sv
// Property checker for elevator_floor_ctrl: the car never heads past either
// end of the shaft and the comparator flags stay consistent with the target.
module elevator_floor_ctrl_chk #(
  parameter int NUM_FLOORS = 8,
  parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
  input logic               i_clk,
  input logic               i_rst,
  input logic               i_moving_up,
  input logic               i_moving_down,
  input logic               i_target_valid,
  input logic               i_lt,
  input logic               i_gt,
  input logic               i_eq,
  input logic [FLOOR_W-1:0] i_current_floor
);

  a_no_up_at_top: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_moving_up && (int'(i_current_floor) == NUM_FLOORS - 1)));

  a_no_down_at_bottom: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_moving_down && (i_current_floor == '0)));

  a_cmp_onehot: assert property (@(posedge i_clk) disable iff (i_rst)
    i_target_valid |-> $onehot({i_lt, i_gt, i_eq}));

  a_cmp_idle: assert property (@(posedge i_clk) disable iff (i_rst)
    !i_target_valid |-> !(i_lt || i_gt || i_eq));

endmodule

// File: rtl/floor_cmp.sv
// Car-vs-target magnitude comparator. lt means the target lies below the car,
// gt means it lies above; all outputs are held low while disabled.
module floor_cmp #(
  parameter int FLOOR_W = 3
) (
  input  logic               i_en,
  input  logic [FLOOR_W-1:0] i_cur,
  input  logic [FLOOR_W-1:0] i_tgt,
  output logic               o_lt,
  output logic               o_gt,
  output logic               o_eq
);

  assign o_lt = i_en & (i_cur > i_tgt);
  assign o_gt = i_en & (i_cur < i_tgt);
  assign o_eq = i_en & (i_cur == i_tgt);

endmodule

// File: rtl/elevator_floor_ctrl.sv
// SCAN-scheduled elevator controller: latches floor requests, times travel and
// door dwell, and compares the car position against the scheduled target.
module elevator_floor_ctrl
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS  = 8,
  parameter int FLOOR_W     = $clog2(NUM_FLOORS),
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 6,
  parameter int RESET_FLOOR = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  input  logic [FLOOR_W-1:0]    i_req_floor,
  output logic                  o_req_err,
  output logic [FLOOR_W-1:0]    o_current_floor,
  output logic [NUM_FLOORS-1:0] o_pending,
  output logic                  o_moving_up,
  output logic                  o_moving_down,
  output logic                  o_door_open,
  output logic                  o_arrive,
  output logic                  o_target_valid,
  output logic                  o_lt,
  output logic                  o_gt,
  output logic                  o_eq
);

  localparam int MCNT_W = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam int DCNT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [MCNT_W-1:0] MOVE_LAST = MCNT_W'(MOVE_CYCLES - 1);
  localparam logic [DCNT_W-1:0] DOOR_LAST = DCNT_W'(DOOR_CYCLES - 1);

  logic [1:0]            r_state;
  logic [FLOOR_W-1:0]    r_current_floor;
  logic [NUM_FLOORS-1:0] r_pending;
  logic [MCNT_W-1:0]     r_move_cnt;
  logic [DCNT_W-1:0]     r_door_cnt;
  logic                  r_last_dir;
  logic                  r_arrive;
  logic                  r_req_err;

  logic                   w_req_ok;
  logic                   w_req_bad;
  logic                   w_door_hit;
  logic [NUM_FLOORS-1:0]  w_req_mask;
  logic [NUM_FLOORS-1:0]  w_set_mask;
  logic [NUM_FLOORS-1:0]  w_clear_mask;
  logic [MAX_FLOORS-1:0]  w_pend_ext;
  logic [MAX_FLOOR_W-1:0] w_cur_ext;
  logic                   w_cur_hit;
  logic                   w_above;
  logic                   w_below;
  logic [FLOOR_W-1:0]     w_next_floor;
  logic                   w_nf_hit;
  logic                   w_nf_beyond;
  logic [FLOOR_W-1:0]     w_target;
  logic                   w_cmp_en;

  logic [1:0]             w_state_nxt;
  logic [FLOOR_W-1:0]     w_floor_nxt;
  logic [MCNT_W-1:0]      w_move_cnt_nxt;
  logic [DCNT_W-1:0]      w_door_cnt_nxt;
  logic                   w_dir_nxt;
  logic                   w_arrive_nxt;

  assign w_req_ok   = i_req_valid & (int'(i_req_floor) < NUM_FLOORS);
  assign w_req_bad  = i_req_valid & ~w_req_ok;
  assign w_req_mask = w_req_ok ? (NUM_FLOORS'(1'b1) << i_req_floor) : '0;
  // A call for the floor whose door is already open only extends the dwell.
  assign w_door_hit = w_req_ok & (r_state == ST_DOOR) & (i_req_floor == r_current_floor);
  assign w_set_mask = w_door_hit ? '0 : w_req_mask;

  assign w_pend_ext = MAX_FLOORS'(r_pending);
  assign w_cur_ext  = MAX_FLOOR_W'(r_current_floor);
  assign w_cur_hit  = |(r_pending & (NUM_FLOORS'(1'b1) << r_current_floor));
  assign w_above    = any_above(w_pend_ext, w_cur_ext);
  assign w_below    = any_below(w_pend_ext, w_cur_ext);

  // Arrival floor for the move in progress and what is still wanted past it.
  always_comb begin
    if (r_state == ST_MOVE_UP) begin
      w_next_floor = r_current_floor + FLOOR_W'(1);
      w_nf_beyond  = any_above(w_pend_ext, MAX_FLOOR_W'(w_next_floor));
    end else begin
      w_next_floor = r_current_floor - FLOOR_W'(1);
      w_nf_beyond  = any_below(w_pend_ext, MAX_FLOOR_W'(w_next_floor));
    end
  end

  assign w_nf_hit = |((r_pending | w_req_mask) & (NUM_FLOORS'(1'b1) << w_next_floor));

  // SCAN target: own floor first, then nearest ahead, then nearest behind.
  always_comb begin
    if (w_cur_hit) begin
      w_target = r_current_floor;
    end else if (r_last_dir == DIR_UP) begin
      w_target = w_above ? FLOOR_W'(nearest_above(w_pend_ext, w_cur_ext))
                         : FLOOR_W'(nearest_below(w_pend_ext, w_cur_ext));
    end else begin
      w_target = w_below ? FLOOR_W'(nearest_below(w_pend_ext, w_cur_ext))
                         : FLOOR_W'(nearest_above(w_pend_ext, w_cur_ext));
    end
  end

  assign w_cmp_en = (|r_pending) & ~i_rst;

  // Next-state logic for the car FSM and its travel/dwell counters.
  always_comb begin
    w_state_nxt    = r_state;
    w_floor_nxt    = r_current_floor;
    w_move_cnt_nxt = r_move_cnt;
    w_door_cnt_nxt = r_door_cnt;
    w_dir_nxt      = r_last_dir;
    w_clear_mask   = '0;
    w_arrive_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_move_cnt_nxt = '0;
        w_door_cnt_nxt = '0;
        if (w_cur_hit) begin
          w_state_nxt  = ST_DOOR;
          w_clear_mask = NUM_FLOORS'(1'b1) << r_current_floor;
          w_arrive_nxt = 1'b1;
        end else if (w_above && ((r_last_dir == DIR_UP) || !w_below)) begin
          w_state_nxt = ST_MOVE_UP;
          w_dir_nxt   = DIR_UP;
        end else if (w_below) begin
          w_state_nxt = ST_MOVE_DOWN;
          w_dir_nxt   = DIR_DN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MOVE_UP, ST_MOVE_DOWN: begin
        if (r_move_cnt == MOVE_LAST) begin
          w_move_cnt_nxt = '0;
          w_floor_nxt    = w_next_floor;
          if (w_nf_hit) begin
            w_state_nxt    = ST_DOOR;
            w_clear_mask   = NUM_FLOORS'(1'b1) << w_next_floor;
            w_arrive_nxt   = 1'b1;
            w_door_cnt_nxt = '0;
          end else if (!w_nf_beyond) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = r_state;
          end
        end else begin
          w_move_cnt_nxt = r_move_cnt + MCNT_W'(1);
        end
      end
      ST_DOOR: begin
        if (w_door_hit) begin
          w_door_cnt_nxt = '0;
        end else if (r_door_cnt == DOOR_LAST) begin
          w_door_cnt_nxt = '0;
          w_state_nxt    = ST_IDLE;
        end else begin
          w_door_cnt_nxt = r_door_cnt + DCNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, position, request mask and pulse registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= ST_IDLE;
      r_current_floor <= FLOOR_W'(RESET_FLOOR);
      r_pending       <= '0;
      r_move_cnt      <= '0;
      r_door_cnt      <= '0;
      r_last_dir      <= DIR_UP;
      r_arrive        <= 1'b0;
      r_req_err       <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_current_floor <= w_floor_nxt;
      r_pending       <= (r_pending | w_set_mask) & ~w_clear_mask;
      r_move_cnt      <= w_move_cnt_nxt;
      r_door_cnt      <= w_door_cnt_nxt;
      r_last_dir      <= w_dir_nxt;
      r_arrive        <= w_arrive_nxt;
      r_req_err       <= w_req_bad;
    end
  end

  floor_cmp #(
    .FLOOR_W (FLOOR_W)
  ) u_target_cmp (
    .i_en  (w_cmp_en),
    .i_cur (r_current_floor),
    .i_tgt (w_target),
    .o_lt  (o_lt),
    .o_gt  (o_gt),
    .o_eq  (o_eq)
  );

  assign o_req_err       = r_req_err;
  assign o_current_floor = r_current_floor;
  assign o_pending       = r_pending;
  assign o_moving_up     = (r_state == ST_MOVE_UP);
  assign o_moving_down   = (r_state == ST_MOVE_DOWN);
  assign o_door_open     = (r_state == ST_DOOR);
  assign o_arrive        = r_arrive;
  assign o_target_valid  = |r_pending;

endmodule

// File: tb/tb_elevator_floor_ctrl.sv
// Scoreboard bench: an 8-floor and a 6-floor controller share one random
// request stream and are compared cycle by cycle against a behavioural model.
module tb_elevator_floor_ctrl;

  localparam int MOVE_CYCLES = 4;
  localparam int DOOR_CYCLES = 6;
  localparam int NCYC        = 4000;
  localparam int MD_IDLE = 0, MD_UP = 1, MD_DOWN = 2, MD_DOOR = 3;

  typedef struct packed {
    logic [3:0]  floor;
    logic [15:0] pend;
    logic [8:0]  flags;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [2:0] req_floor = 3'd0;

  logic       a_err, a_up, a_down, a_door, a_arr, a_tv, a_lt, a_gt, a_eq;
  logic [2:0] a_floor;
  logic [7:0] a_pend;
  logic       b_err, b_up, b_down, b_door, b_arr, b_tv, b_lt, b_gt, b_eq;
  logic [2:0] b_floor;
  logic [5:0] b_pend;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   rst_hold = 0;
  int   sel;
  exp_t q0[$];
  exp_t q1[$];

  int          m_pos[2];
  int          m_mode[2];
  int          m_timer[2];
  logic [15:0] m_pend[2];
  bit          m_up[2];
  bit          m_arr[2];
  bit          m_err[2];

  always #5 clk = ~clk;

  elevator_floor_ctrl #(.NUM_FLOORS(8), .MOVE_CYCLES(MOVE_CYCLES), .DOOR_CYCLES(DOOR_CYCLES)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_floor(req_floor),
    .o_req_err(a_err), .o_current_floor(a_floor), .o_pending(a_pend),
    .o_moving_up(a_up), .o_moving_down(a_down), .o_door_open(a_door), .o_arrive(a_arr),
    .o_target_valid(a_tv), .o_lt(a_lt), .o_gt(a_gt), .o_eq(a_eq));

  elevator_floor_ctrl #(.NUM_FLOORS(6), .MOVE_CYCLES(MOVE_CYCLES), .DOOR_CYCLES(DOOR_CYCLES)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_floor(req_floor),
    .o_req_err(b_err), .o_current_floor(b_floor), .o_pending(b_pend),
    .o_moving_up(b_up), .o_moving_down(b_down), .o_door_open(b_door), .o_arrive(b_arr),
    .o_target_valid(b_tv), .o_lt(b_lt), .o_gt(b_gt), .o_eq(b_eq));

  elevator_floor_ctrl_chk #(.NUM_FLOORS(8)) u_chk_a (
    .i_clk(clk), .i_rst(rst), .i_moving_up(a_up), .i_moving_down(a_down),
    .i_target_valid(a_tv), .i_lt(a_lt), .i_gt(a_gt), .i_eq(a_eq), .i_current_floor(a_floor));

  elevator_floor_ctrl_chk #(.NUM_FLOORS(6)) u_chk_b (
    .i_clk(clk), .i_rst(rst), .i_moving_up(b_up), .i_moving_down(b_down),
    .i_target_valid(b_tv), .i_lt(b_lt), .i_gt(b_gt), .i_eq(b_eq), .i_current_floor(b_floor));

  function automatic int nfl(int k);
    return (k == 0) ? 8 : 6;
  endfunction

  // Closest pending floor strictly above (up) or below pos, -1 if none.
  function automatic int nearest(logic [15:0] mask, int pos, bit up);
    for (int d = 1; d < 16; d++) begin
      int f;
      f = up ? pos + d : pos - d;
      if (f >= 0 && f < 16 && mask[f]) return f;
    end
    return -1;
  endfunction

  function automatic void open_door(int k);
    m_mode[k]          = MD_DOOR;
    m_timer[k]         = DOOR_CYCLES;
    m_pend[k][m_pos[k]] = 1'b0;
    m_arr[k]           = 1'b1;
  endfunction

  // One clock edge of the car as described by the scheduling rules.
  function automatic void model_step(int k, bit r, bit rv, int rf);
    logic [15:0] old;
    bit ok;
    int p;
    bit ahead_up, ahead_dn;
    if (r) begin
      m_pos[k] = 0; m_pend[k] = '0; m_mode[k] = MD_IDLE; m_timer[k] = 0;
      m_up[k] = 1'b1; m_arr[k] = 1'b0; m_err[k] = 1'b0;
      return;
    end
    ok       = rv && (rf < nfl(k));
    old      = m_pend[k];
    m_err[k] = rv && !ok;
    m_arr[k] = 1'b0;
    if (ok && !(m_mode[k] == MD_DOOR && rf == m_pos[k])) m_pend[k][rf] = 1'b1;
    case (m_mode[k])
      MD_IDLE: begin
        ahead_up = nearest(old, m_pos[k], 1'b1) >= 0;
        ahead_dn = nearest(old, m_pos[k], 1'b0) >= 0;
        if (old[m_pos[k]]) open_door(k);
        else if (ahead_up && (m_up[k] || !ahead_dn)) begin
          m_mode[k] = MD_UP; m_up[k] = 1'b1; m_timer[k] = MOVE_CYCLES;
        end else if (ahead_dn) begin
          m_mode[k] = MD_DOWN; m_up[k] = 1'b0; m_timer[k] = MOVE_CYCLES;
        end
      end
      MD_UP, MD_DOWN: begin
        m_timer[k] = m_timer[k] - 1;
        if (m_timer[k] == 0) begin
          p = m_pos[k] + ((m_mode[k] == MD_UP) ? 1 : -1);
          m_pos[k] = p;
          if (old[p] || (ok && rf == p)) open_door(k);
          else if (nearest(old, p, m_mode[k] == MD_UP) < 0) m_mode[k] = MD_IDLE;
          else m_timer[k] = MOVE_CYCLES;
        end
      end
      default: begin
        if (ok && rf == m_pos[k]) m_timer[k] = DOOR_CYCLES;
        else begin
          m_timer[k] = m_timer[k] - 1;
          if (m_timer[k] == 0) m_mode[k] = MD_IDLE;
        end
      end
    endcase
  endfunction

  function automatic exp_t model_out(int k, bit r_now);
    exp_t e;
    int t, na, nb;
    bit tv, en;
    tv = (m_pend[k] != 16'd0);
    na = nearest(m_pend[k], m_pos[k], 1'b1);
    nb = nearest(m_pend[k], m_pos[k], 1'b0);
    if (m_pend[k][m_pos[k]]) t = m_pos[k];
    else if (m_up[k]) t = (na >= 0) ? na : nb;
    else t = (nb >= 0) ? nb : na;
    en = tv && !r_now;
    e.floor = 4'(m_pos[k]);
    e.pend  = m_pend[k];
    e.flags = {m_mode[k] == MD_UP, m_mode[k] == MD_DOWN, m_mode[k] == MD_DOOR, m_arr[k], m_err[k],
               tv, en && (m_pos[k] > t), en && (m_pos[k] < t), en && (m_pos[k] == t)};
    return e;
  endfunction

  task automatic check(string nm, logic [15:0] act, logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // Monitor: pops one expectation per DUT each cycle, mid-period.
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      check("A floor", 16'(a_floor), 16'(e.floor));
      check("A pending", 16'(a_pend), e.pend);
      check("A flags", 16'({a_up, a_down, a_door, a_arr, a_err, a_tv, a_lt, a_gt, a_eq}), 16'(e.flags));
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check("B floor", 16'(b_floor), 16'(e.floor));
      check("B pending", 16'(b_pend), e.pend);
      check("B flags", 16'({b_up, b_down, b_door, b_arr, b_err, b_tv, b_lt, b_gt, b_eq}), 16'(e.flags));
    end
  end

  initial begin
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      model_step(0, rst, req_valid, int'(req_floor));
      model_step(1, rst, req_valid, int'(req_floor));
      #1;
      req_valid = 1'b0;
      if (cyc < 3) rst = 1'b1;
      else if (rst_hold > 0) begin rst = 1'b1; rst_hold--; end
      else if (cyc > 200 && $urandom_range(0, 499) == 0) begin rst = 1'b1; rst_hold = 1; end
      else rst = 1'b0;
      if (cyc == 5) begin
        req_valid = 1'b1; req_floor = 3'd5;
      end else if (cyc > 60) begin
        sel = $urandom_range(0, 15);
        if (sel < 2) begin
          req_valid = 1'b1; req_floor = 3'($urandom_range(0, 7));
        end else if (sel < 5 && (m_mode[0] == MD_UP || m_mode[0] == MD_DOWN) && m_timer[0] == 1) begin
          req_valid = 1'b1; req_floor = 3'(m_pos[0] + ((m_mode[0] == MD_UP) ? 1 : -1));
        end else if (sel == 5 && m_mode[0] == MD_DOOR) begin
          req_valid = 1'b1; req_floor = 3'(m_pos[0]);
        end
      end
      q0.push_back(model_out(0, rst));
      q1.push_back(model_out(1, rst));
    end
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
